// File: rtl/fetch_unit.sv
// Instruction fetch unit: 16x8 program memory, PC, IDLE/RUN/HALT control.
// Ports: clk, reset (sync, active-high), prog_we/prog_addr/prog_data (load),
//   run_req (start at address 0), step (only with FETCH_STEP_EN), pc_load
//   (jump from decoder), op_out/im_out (fetched word), pc_out, instr_valid,
//   state_out, retired (saturating count). Optional macro: FETCH_STEP_EN.
module fetch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       run_req,
`ifdef FETCH_STEP_EN
    input  logic       step,
`endif
    input  logic       pc_load,
    output logic [3:0] op_out,
    output logic [3:0] im_out,
    output logic [3:0] pc_out,
    output logic       instr_valid,
    output logic [1:0] state_out,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ret_q, ret_d;
    logic [7:0] mem_q [16];
    logic [7:0] word;
    logic       adv;
    logic       run;

    assign run  = (state_q == RUN);
    assign word = mem_q[pc_q];

`ifdef FETCH_STEP_EN
    assign adv = run && step;
`else
    assign adv = run;
`endif

    // Memory is deliberately left out of reset so programs survive it.
    always_ff @(posedge clk) begin
        if (!reset && prog_we && (state_q == IDLE)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 4'd0;
            ret_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (run_req) begin
                    state_d = RUN;
                    pc_d    = 4'd0;
                    ret_d   = 8'd0;
                end
            end
            RUN: begin
                if (adv) begin
                    pc_d  = pc_load ? word[3:0] : pc_q + 4'd1;
                    ret_d = (ret_q == 8'hFF) ? ret_q : ret_q + 8'd1;
                    // A jump onto itself retires and then parks the unit.
                    if (pc_load && (word[3:0] == pc_q)) begin
                        state_d = HALT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign op_out      = run ? word[7:4] : 4'd0;
    assign im_out      = run ? word[3:0] : 4'd0;
    assign pc_out      = pc_q;
    assign instr_valid = adv;
    assign state_out   = state_q;
    assign retired     = ret_q;

endmodule
